// File: rtl/bp_resolver_if.sv
// Prediction/resolve/update bundle between a branch predictor and bp_resolver.
// The predictor side is the master; the resolver is the slave.
interface bp_resolver_if #(
  parameter int IDX_W = 4
);
  logic             pred_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             mispredict;
  logic             res_err;

  modport master (
    output pred_valid, pred_taken, pred_idx, res_valid, res_taken,
    input  pred_ready, upd_valid, upd_idx, upd_taken, mispredict, res_err
  );

  modport slave (
    input  pred_valid, pred_taken, pred_idx, res_valid, res_taken,
    output pred_ready, upd_valid, upd_idx, upd_taken, mispredict, res_err
  );
endinterface

// File: rtl/bp_resolver.sv
// In-order queue of in-flight branch predictions; each resolve pops the oldest entry
// and emits a registered training update plus saturating hit/miss statistics.
module bp_resolver #(
  parameter int  DEPTH = 4,
  parameter int  IDX_W = 4,
  parameter int  CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  bp_resolver_if.slave     bus,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef struct packed {
    logic             taken;
    logic [IDX_W-1:0] idx;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_nxt_s;
  logic [CNT_W-1:0] hit_r;
  logic [CNT_W-1:0] miss_r;
  logic             upd_valid_r;
  logic [IDX_W-1:0] upd_idx_r;
  logic             upd_taken_r;
  logic             mispredict_r;
  logic             res_err_r;
  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             err_s;
  logic             head_mis_s;
  entry_t           head_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Queue control: accept/pop decisions come only from registered occupancy.
  always_comb begin
    ready_s    = (occ_r < OCC_W'(DEPTH));
    push_s     = bus.pred_valid & ready_s;
    pop_s      = bus.res_valid & (occ_r != {OCC_W{1'b0}});
    err_s      = bus.res_valid & (occ_r == {OCC_W{1'b0}});
    head_s     = mem_r[rd_ptr_r];
    head_mis_s = head_s.taken ^ bus.res_taken;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
      2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Entry storage, written at the tail on each accepted prediction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{taken: 1'b0, idx: {IDX_W{1'b0}}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= '{taken: bus.pred_taken, idx: bus.pred_idx};
    end
  end

  // Pointers, occupancy, registered update pulses and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= {OCC_W{1'b0}};
      hit_r        <= {CNT_W{1'b0}};
      miss_r       <= {CNT_W{1'b0}};
      upd_valid_r  <= 1'b0;
      upd_idx_r    <= {IDX_W{1'b0}};
      upd_taken_r  <= 1'b0;
      mispredict_r <= 1'b0;
      res_err_r    <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
        upd_idx_r   <= head_s.idx;
        upd_taken_r <= bus.res_taken;
      end
      occ_r        <= occ_nxt_s;
      upd_valid_r  <= pop_s;
      mispredict_r <= pop_s & head_mis_s;
      res_err_r    <= err_s;
      if (pop_s & ~head_mis_s) begin
        hit_r <= sat_inc(hit_r);
      end
      if (pop_s & head_mis_s) begin
        miss_r <= sat_inc(miss_r);
      end
    end
  end

  assign bus.pred_ready = ready_s;
  assign bus.upd_valid  = upd_valid_r;
  assign bus.upd_idx    = upd_idx_r;
  assign bus.upd_taken  = upd_taken_r;
  assign bus.mispredict = mispredict_r;
  assign bus.res_err    = res_err_r;
  assign occupancy      = occ_r;
  assign hit_count      = hit_r;
  assign miss_count     = miss_r;

endmodule
